// File: rtl/mbgd_grad_update.sv
// Mini-batch gradient stage: accumulates err*x_j over B samples, then applies
// one saturating step teta_j -= acc_j >>> LR_SHIFT and publishes the new teta.
module mbgd_grad_update #(
    parameter int DW       = 8,
    parameter int N        = 8,
    parameter int B        = 4,
    parameter int B_bit    = 2,
    parameter int LR_SHIFT = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              teta_load,
    input  logic [DW*N-1:0]   teta_init,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     h,
    input  logic              y,
    input  logic [DW*N-1:0]   x,
    output logic [DW*N-1:0]   teta,
    output logic              teta_valid,
    output logic [B_bit-1:0]  batch_cnt
);

    localparam int EW = DW + 1;            // err width
    localparam int PW = 2 * DW + 1;        // err*x product width
    localparam int AW = 2 * DW + 1 + B_bit; // accumulator width, sized so B products never overflow

    localparam logic signed [EW-1:0] Y_ONE    = EW'((1 << DW) - 1);
    localparam logic signed [EW-1:0] Y_ZERO   = '0;
    localparam logic signed [AW-1:0] SAT_MAX  = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(1 << (DW - 1)));
    localparam logic [DW-1:0]        POS_LIM  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        NEG_LIM  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [B_bit-1:0]     LAST_CNT = B_bit'(B - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [EW-1:0] y_val;
    logic signed [EW-1:0] err;
    logic signed [PW-1:0] prod     [N];
    logic signed [AW-1:0] acc      [N];
    logic signed [AW-1:0] diff     [N];
    logic [DW-1:0]        teta_sat [N];
    logic                 accept;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready & enable;

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            ACCUM:   if (in_valid && batch_cnt == LAST_CNT) state_next = UPDATE;
            UPDATE:  state_next = ACCUM;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        y_val = y ? Y_ONE : Y_ZERO;
        err   = $signed({1'b0, h}) - y_val;
        for (int j = 0; j < N; j++) begin
            prod[j] = PW'(err) * PW'($signed({1'b0, x[DW*j +: DW]}));
            // Arithmetic shift floors toward -inf, so a negative sum steps up by one extra LSB.
            diff[j] = AW'($signed(teta[DW*j +: DW])) - (acc[j] >>> LR_SHIFT);
            if (diff[j] > SAT_MAX)
                teta_sat[j] = POS_LIM;
            else if (diff[j] < SAT_MIN)
                teta_sat[j] = NEG_LIM;
            else
                teta_sat[j] = diff[j][DW-1:0];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of the order of statements.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else if (teta_load)
            state <= ACCUM;
        else if (enable)
            state <= state_next;
    end

    // NOTE: the accumulators are a small flop array rather than a RAM, so
    // clearing them in reset and on teta_load is legal and cheap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            teta       <= '0;
            teta_valid <= 1'b0;
            batch_cnt  <= '0;
            for (int j = 0; j < N; j++) acc[j] <= '0;
        end else if (teta_load) begin
            teta       <= teta_init;
            teta_valid <= 1'b0;
            batch_cnt  <= '0;
            for (int j = 0; j < N; j++) acc[j] <= '0;
        end else if (!enable) begin
            teta_valid <= 1'b0;
        end else begin
            teta_valid <= 1'b0;
            if (accept) begin
                batch_cnt <= batch_cnt + B_bit'(1);
                for (int j = 0; j < N; j++) acc[j] <= acc[j] + AW'(prod[j]);
            end
            if (state == UPDATE) begin
                teta_valid <= 1'b1;
                for (int j = 0; j < N; j++) begin
                    teta[DW*j +: DW] <= teta_sat[j];
                    acc[j]           <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbgd_grad_update.sv
// Directed bench for mbgd_grad_update: hand-computed batch results, freeze,
// UPDATE backpressure, mid-batch reload and reset during UPDATE.
module tb_mbgd_grad_update;

    localparam int DW = 8;
    localparam int N  = 8;

    logic              clk;
    logic              resetn;
    logic              enable;
    logic              teta_load;
    logic [DW*N-1:0]   teta_init;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     h;
    logic              y;
    logic [DW*N-1:0]   x;
    logic [DW*N-1:0]   teta;
    logic              teta_valid;
    logic [1:0]        batch_cnt;

    int checks = 0;
    int errors = 0;

    mbgd_grad_update #(.DW(8), .N(8), .B(4), .B_bit(2), .LR_SHIFT(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .teta_load  (teta_load),
        .teta_init  (teta_init),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .h          (h),
        .y          (y),
        .x          (x),
        .teta       (teta),
        .teta_valid (teta_valid),
        .batch_cnt  (batch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW*N-1:0] init);
        teta_init = init;
        teta_load = 1'b1;
        step();
        teta_load = 1'b0;
    endtask

    task automatic set_sample(input logic [7:0] hv, input logic yv, input logic [DW*N-1:0] xv);
        h = hv;
        y = yv;
        x = xv;
    endtask

    // Four accepts followed by the UPDATE edge; in_valid stays high throughout.
    task automatic run_batch(input string tag, input logic [DW*N-1:0] exp_teta);
        in_valid = 1'b1;
        repeat (4) step();
        check({tag, "_ready_low"}, in_ready, 1'b0);
        check({tag, "_valid_pre"}, teta_valid, 1'b0);
        step();
        check({tag, "_valid"}, teta_valid, 1'b1);
        check({tag, "_teta"}, teta, exp_teta);
        check({tag, "_cnt_after"}, batch_cnt, 2'd0);
        in_valid = 1'b0;
        step();
        check({tag, "_valid_drop"}, teta_valid, 1'b0);
    endtask

    initial begin
        logic [DW*N-1:0] x16;
        logic [DW*N-1:0] xmix;
        x16 = {N{8'd16}};
        for (int j = 0; j < N; j++) xmix[DW*j +: DW] = 8'(32 * j);

        resetn = 1'b0; enable = 1'b1; teta_load = 1'b0; teta_init = '0;
        in_valid = 1'b1; h = '0; y = 1'b0; x = '0;
        step();
        check("rst_teta", teta, 64'h0);
        check("rst_cnt", batch_cnt, 2'd0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_valid", teta_valid, 1'b0);
        resetn = 1'b1;
        step();
        check("idle_ready", in_ready, 1'b0);
        check("idle_cnt", batch_cnt, 2'd0);

        // Basic step: err=255, acc=16320, delta=63.
        in_valid = 1'b0;
        load('0);
        check("load_ready", in_ready, 1'b1);
        set_sample(8'd255, 1'b0, x16);
        in_valid = 1'b1;
        step(); check("basic_cnt1", batch_cnt, 2'd1);
        step(); check("basic_cnt2", batch_cnt, 2'd2);
        step(); check("basic_cnt3", batch_cnt, 2'd3);
        step();
        check("basic_cnt0", batch_cnt, 2'd0);
        check("basic_ready_low", in_ready, 1'b0);
        check("basic_valid_pre", teta_valid, 1'b0);
        step();
        check("basic_valid", teta_valid, 1'b1);
        check("basic_teta", teta, {N{8'hC1}});
        check("basic_ready_back", in_ready, 1'b1);
        check("basic_no_extra", batch_cnt, 2'd0);
        in_valid = 1'b0;
        step();
        check("basic_valid_drop", teta_valid, 1'b0);

        // Negative error, floor shift: -16320 >>> 8 = -64.
        load('0);
        set_sample(8'd0, 1'b1, x16);
        run_batch("neg", {N{8'h40}});

        // Saturation in both directions.
        load({N{8'h9C}});
        set_sample(8'd255, 1'b0, x16);
        run_batch("sat_lo", {N{8'h80}});
        load({N{8'h64}});
        set_sample(8'd0, 1'b1, x16);
        run_batch("sat_hi", {N{8'h7F}});

        // Per-element slicing: teta_j = -64*j, clamped at -128 from j=2.
        load('0);
        set_sample(8'd128, 1'b0, xmix);
        run_batch("mix", {{6{8'h80}}, 8'hC0, 8'h00});

        // Enable freeze mid-batch and during UPDATE.
        load('0);
        set_sample(8'd255, 1'b0, x16);
        in_valid = 1'b1;
        repeat (2) step();
        enable = 1'b0;
        repeat (5) step();
        check("frz_cnt", batch_cnt, 2'd2);
        check("frz_teta", teta, 64'h0);
        check("frz_ready", in_ready, 1'b1);
        enable = 1'b1;
        repeat (2) step();
        check("frz_cnt0", batch_cnt, 2'd0);
        enable = 1'b0;
        repeat (2) step();
        check("frz_upd_ready", in_ready, 1'b0);
        check("frz_upd_valid", teta_valid, 1'b0);
        check("frz_upd_teta", teta, 64'h0);
        enable = 1'b1;
        step();
        check("frz_valid", teta_valid, 1'b1);
        check("frz_result", teta, {N{8'hC1}});
        enable = 1'b0;
        step();
        check("frz_valid_forced", teta_valid, 1'b0);
        enable = 1'b1;
        in_valid = 1'b0;
        step();

        // Reload mid-batch: partial accumulation must be discarded.
        load('0);
        in_valid = 1'b1;
        repeat (2) step();
        check("rld_cnt2", batch_cnt, 2'd2);
        teta_init = {N{8'h05}};
        teta_load = 1'b1;
        step();
        teta_load = 1'b0;
        check("rld_cnt0", batch_cnt, 2'd0);
        check("rld_teta", teta, {N{8'h05}});
        repeat (3) step();
        check("rld_cnt3", batch_cnt, 2'd3);
        check("rld_ready", in_ready, 1'b1);
        check("rld_valid_none", teta_valid, 1'b0);
        step();
        check("rld_ready_low", in_ready, 1'b0);
        step();
        check("rld_valid", teta_valid, 1'b1);
        check("rld_result", teta, {N{8'hC6}});

        // Reset while in UPDATE.
        repeat (4) step();
        check("rstu_in_update", in_ready, 1'b0);
        resetn = 1'b0;
        step();
        check("rstu_teta", teta, 64'h0);
        check("rstu_valid", teta_valid, 1'b0);
        check("rstu_cnt", batch_cnt, 2'd0);
        resetn = 1'b1;
        step();
        check("rstu_valid_after", teta_valid, 1'b0);
        check("rstu_idle", in_ready, 1'b0);
        check("rstu_teta_after", teta, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
